// File: rtl/mem_scan_ctrl.sv
// Step/auto-run RAM address scanner with single-byte write and optional clear-all sweep.
// Optional feature: define SCAN_CLEAR_EN to build the CLEAR state (clr port is ignored otherwise).
module mem_scan_ctrl #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  input  logic       run,
  input  logic       wr_req,
  input  logic [7:0] wr_data,
  input  logic       clr,
  output logic [7:0] address,
  output logic       we,
  output logic [7:0] ram_din,
  output logic       wr_ack,
  output logic       wrap,
  output logic       busy
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

`ifdef SCAN_CLEAR_EN
  typedef enum logic [2:0] {IDLE, RUN, WRITE, WACK, CLEAR} state_t;
`else
  typedef enum logic [2:0] {IDLE, RUN, WRITE, WACK} state_t;
  logic unused_clr;
  assign unused_clr = clr;
`endif

  state_t        state;
  logic [TW-1:0] tick;
  logic          step_prev;
  logic          step_edge;

  assign step_edge = step & ~step_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      address   <= 8'h00;
      we        <= 1'b0;
      ram_din   <= 8'h00;
      wr_ack    <= 1'b0;
      wrap      <= 1'b0;
      busy      <= 1'b0;
      tick      <= '0;
      // High so a step held across reset release is not seen as an edge.
      step_prev <= 1'b1;
    end else begin
      step_prev <= step;
      wrap      <= 1'b0;
      wr_ack    <= 1'b0;
      case (state)
        IDLE: begin
`ifdef SCAN_CLEAR_EN
          if (clr) begin
            state   <= CLEAR;
            address <= 8'h00;
            we      <= 1'b1;
            ram_din <= 8'h00;
            busy    <= 1'b1;
          end else
`endif
          if (wr_req) begin
            state   <= WRITE;
            we      <= 1'b1;
            ram_din <= wr_data;
            busy    <= 1'b1;
          end else if (run) begin
            state <= RUN;
            tick  <= '0;
            busy  <= 1'b1;
          end else if (step_edge) begin
            address <= address + 8'd1;
            wrap    <= (address == 8'hFF);
          end
        end
        RUN: begin
          if (wr_req) begin
            state   <= WRITE;
            we      <= 1'b1;
            ram_din <= wr_data;
          end else if (!run) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tick == TICK_LAST) begin
            tick    <= '0;
            address <= address + 8'd1;
            wrap    <= (address == 8'hFF);
          end else begin
            tick <= tick + TW'(1);
          end
        end
        WRITE: begin
          state   <= WACK;
          we      <= 1'b0;
          wr_ack  <= 1'b1;
          address <= address + 8'd1;
          wrap    <= (address == 8'hFF);
        end
        WACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
`ifdef SCAN_CLEAR_EN
        CLEAR: begin
          address <= address + 8'd1;
          wrap    <= (address == 8'hFF);
          // The cycle that writes 0xFF is the last one of the sweep.
          if (address == 8'hFF) begin
            state <= IDLE;
            we    <= 1'b0;
            busy  <= 1'b0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          we    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Cycle-exact scoreboard bench for mem_scan_ctrl: each driven cycle queues the expected
// output snapshot {busy, wrap, wr_ack, we, ram_din, address}, popped and checked after the edge.
module tb_mem_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       step = 1'b1;
  logic       run = 1'b0;
  logic       wr_req = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] address;
  logic       we;
  logic [7:0] ram_din;
  logic       wr_ack;
  logic       wrap;
  logic       busy;

  mem_scan_ctrl #(.TICK_DIV(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .step    (step),
    .run     (run),
    .wr_req  (wr_req),
    .wr_data (wr_data),
    .clr     (clr),
    .address (address),
    .we      (we),
    .ram_din (ram_din),
    .wr_ack  (wr_ack),
    .wrap    (wrap),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  logic [19:0] obs;
  assign obs = {busy, wrap, wr_ack, we, ram_din, address};

  typedef struct {
    string       tag;
    logic [19:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [19:0] snap(input logic b, input logic w, input logic a,
                                       input logic e, input logic [7:0] d, input logic [7:0] ad);
    return {b, w, a, e, d, ad};
  endfunction

  task automatic check_val(input string tag, input logic [19:0] got, input logic [19:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got busy=%b wrap=%b ack=%b we=%b din=%h addr=%h, expected busy=%b wrap=%b ack=%b we=%b din=%h addr=%h",
               tag, got[19], got[18], got[17], got[16], got[15:8], got[7:0],
               want[19], want[18], want[17], want[16], want[15:8], want[7:0]);
    end else begin
      $display("ok   %s: busy=%b wrap=%b ack=%b we=%b din=%h addr=%h",
               tag, got[19], got[18], got[17], got[16], got[15:8], got[7:0]);
    end
  endtask

  // One transaction: drive inputs, queue expectation, clock once, pop and compare.
  task automatic cyc(input string tag, input logic s, input logic r, input logic wq,
                     input logic [7:0] wd, input logic c, input logic [19:0] want);
    exp_t e;
    exp_t it;
    step    = s;
    run     = r;
    wr_req  = wq;
    wr_data = wd;
    clr     = c;
    e.tag = tag;
    e.val = want;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    it = sb_q.pop_front();
    check_val(it.tag, obs, it.val);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] din;
    a   = 8'h00;
    din = 8'h00;

    repeat (2) @(posedge clock);
    #1;
    check_val("reset_state", obs, snap(0, 0, 0, 0, 8'h00, 8'h00));
    reset = 1'b0;
    cyc("step_held_thru_reset", 1, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));
    cyc("step_low", 0, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));

    for (int k = 0; k < 3; k++) begin
      a = a + 8'd1;
      cyc("step_edge", 1, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));
      repeat (4) cyc("step_hold", 1, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));
      cyc("step_release", 0, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));
    end

    while (a != 8'h10) begin
      a = a + 8'd1;
      cyc("step_to_10", 1, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));
      cyc("step_to_10_low", 0, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));
    end

    din = 8'hA5;
    cyc("wr_write", 0, 0, 1, 8'hA5, 0, snap(1, 0, 0, 1, din, 8'h10));
    cyc("wr_ack_2nd_req_ignored", 0, 0, 1, 8'h3C, 0, snap(1, 0, 1, 0, din, 8'h11));
    cyc("wr_idle", 0, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, 8'h11));
    cyc("wr_no_queue", 0, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, 8'h11));
    a = 8'h11;

    while (a != 8'hFF) begin
      a = a + 8'd1;
      cyc("step_to_ff", 1, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));
      cyc("step_to_ff_low", 0, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));
    end
    a = 8'h00;
    cyc("wrap_pulse", 1, 0, 0, 8'h00, 0, snap(0, 1, 0, 0, din, a));
    cyc("wrap_one_cycle", 1, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));
    cyc("wrap_low", 0, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));

    for (int i = 0; i < 17; i++)
      cyc("run_scan", i[0], 1, 0, 8'h00, 0, snap(1, 0, 0, 0, din, 8'(i / 4)));
    a = 8'h04;
    cyc("run_stop", 0, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));

    cyc("run_enter", 0, 1, 0, 8'h00, 0, snap(1, 0, 0, 0, din, a));
    din = 8'h5A;
    cyc("run_write", 0, 1, 1, 8'h5A, 0, snap(1, 0, 0, 1, din, a));
    a = a + 8'd1;
    cyc("run_wack", 0, 1, 0, 8'h00, 0, snap(1, 0, 1, 0, din, a));
    cyc("run_wr_to_idle", 0, 1, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));
    cyc("run_reenter", 0, 1, 0, 8'h00, 0, snap(1, 0, 0, 0, din, a));
    cyc("run_off", 0, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));

`ifdef SCAN_CLEAR_EN
    din = 8'h00;
    cyc("clr_start_beats_wr", 0, 0, 1, 8'h11, 1, snap(1, 0, 0, 1, din, 8'h00));
    for (int i = 1; i < 256; i++)
      cyc("clr_sweep", 0, 0, (i == 7), 8'h22, (i == 9), snap(1, 0, 0, 1, din, 8'(i)));
    cyc("clr_wrap", 0, 0, 0, 8'h00, 0, snap(0, 1, 0, 0, din, 8'h00));
    cyc("clr_idle", 0, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, 8'h00));
    cyc("clr_repeat", 0, 0, 0, 8'h00, 1, snap(1, 0, 0, 1, din, 8'h00));
    for (int i = 1; i < 100; i++)
      cyc("clr_repeat_sweep", 0, 0, 0, 8'h00, 0, snap(1, 0, 0, 1, din, 8'(i)));
    reset = 1'b1;
    #1;
    check_val("clr_reset_abort", obs, snap(0, 0, 0, 0, 8'h00, 8'h00));
    @(posedge clock);
    #1;
    reset = 1'b0;
    a = 8'h00;
    cyc("clr_after_abort", 0, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));
`else
    cyc("clr_ignored", 0, 0, 0, 8'h00, 1, snap(0, 0, 0, 0, din, a));
    din = 8'h77;
    cyc("clr_vs_wr", 0, 0, 1, 8'h77, 1, snap(1, 0, 0, 1, din, a));
    a = a + 8'd1;
    cyc("clr_vs_wr_ack", 0, 0, 0, 8'h00, 0, snap(1, 0, 1, 0, din, a));
    cyc("clr_vs_wr_idle", 0, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, din, a));
`endif

    cyc("wr_before_abort", 0, 0, 1, 8'hC3, 0, snap(1, 0, 0, 1, 8'hC3, a));
    reset = 1'b1;
    #1;
    check_val("wr_reset_abort", obs, snap(0, 0, 0, 0, 8'h00, 8'h00));
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc("wr_no_ack_after_abort", 0, 0, 0, 8'h00, 0, snap(0, 0, 0, 0, 8'h00, 8'h00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_scan_ctrl.md
MEM_SCAN_CTRL -- requirements
Module: mem_scan_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 25_000_000, clock cycles between auto-run address increments (min 2).
REQ-002 clock  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 step  input  1  debounced step button level (synchronous to clock).
REQ-005 run  input  1  auto-run switch level; 1 = free-running scan.
REQ-006 wr_req  input  1  single-cycle write request pulse.
REQ-007 wr_data  input  8  byte written on wr_req.
REQ-008 clr  input  1  single-cycle clear-all request pulse (see REQ-030).
REQ-009 address  output  8  RAM address and display address.
REQ-010 we  output  1  RAM write enable.
REQ-011 ram_din  output  8  RAM write data.
REQ-012 wr_ack  output  1  one-cycle pulse, write complete.
REQ-013 wrap  output  1  one-cycle pulse on every 255->0 address transition.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, RUN, WRITE, WACK, CLEAR.
REQ-016 step SHALL be rising-edge detected internally; one edge = one increment; held level = no further increments.
REQ-017 IDLE request priority SHALL be clr > wr_req > run > step edge, evaluated once per cycle; lower-priority requests that cycle are dropped.
REQ-018 IDLE + step edge: address += 1 next cycle, FSM stays IDLE.
REQ-019 IDLE + run=1: enter RUN next cycle; tick counter cleared to 0.
REQ-020 RUN: tick counter increments every cycle; at TICK_DIV-1 it resets to 0 and address += 1 in the same cycle.
REQ-021 RUN: step edges ignored; run=0 returns to IDLE next cycle with address held; wr_req in RUN SHALL be serviced (RUN->WRITE), returning to IDLE afterward.
REQ-022 WRITE (1 cycle): we=1, ram_din=wr_data captured on the request cycle, address unchanged.
REQ-023 WACK (1 cycle): we=0, wr_ack=1, address += 1, then IDLE; latency wr_req -> wr_ack = 2 cycles.
REQ-024 All address increments SHALL be modulo 256; 255->0 SHALL pulse wrap for exactly one cycle, in every state.
REQ-025 wr_req/clr arriving while in WRITE, WACK or CLEAR SHALL be ignored (no queueing).
REQ-026 we SHALL be 0 outside WRITE and CLEAR; ram_din SHALL hold its last value when we=0.

Reset
REQ-027 On reset assertion, immediately: FSM=IDLE, address=8'h00, we=0, ram_din=8'h00, wr_ack=0, wrap=0, busy=0, tick counter=0.
REQ-028 Step edge-detect register SHALL reset to 1, so a step held through reset release does not increment.
REQ-029 Reset mid-WRITE or mid-CLEAR SHALL abort with we=0 in the same instant; no completion pulse.

Configuration
REQ-030 With SCAN_CLEAR_EN defined: clr in IDLE enters CLEAR; address set to 0; each cycle we=1, ram_din=8'h00, address += 1; after writing address 255 (256 cycles), wrap pulses, address=0, return to IDLE.
REQ-031 Without SCAN_CLEAR_EN: CLEAR state and logic are not built; clr port remains and is ignored; priority becomes wr_req > run > step.

Verification
REQ-032 Reset, then 3 step edges (each held 5 cycles) -> address 0x03; no wrap; busy=0 throughout.
REQ-033 Address 0xFF, one step edge -> address 0x00, wrap=1 for exactly one cycle.
REQ-034 Address 0x10, wr_req with wr_data=0xA5 -> cycle+1 we=1/addr 0x10/ram_din 0xA5; cycle+2 wr_ack=1; address 0x11; second wr_req during WRITE ignored.
REQ-035 TICK_DIV=4, run=1 for 17 cycles from address 0x00 -> address 0x04 on return to IDLE, increments spaced exactly 4 cycles, step edges during RUN ignored.
REQ-036 SCAN_CLEAR_EN defined, clr pulse -> 256 consecutive we=1 cycles with addresses 0x00..0xFF, ram_din=0x00, then wrap, IDLE, address 0x00; reset asserted at cycle 100 of a repeat run -> we=0, address 0x00 immediately.
